// File: rtl/usb_pkt_tx.sv
// USB full-speed packet transmitter: SYNC, PID, optional payload + CRC16, EOP,
// with bit stuffing and NRZI. Optional token/SOF field + CRC5 under USB_TX_TOKEN_EN.
module usb_pkt_tx #(
  parameter int BIT_SAMPLES = 4,
  parameter int MAX_BYTES   = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pkt_start_i,
  input  logic [3:0]  pid_i,
`ifdef USB_TX_TOKEN_EN
  input  logic [10:0] token_i,
`endif
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        tx_en_o,
  output logic        dp_tx_o,
  output logic        dn_tx_o
);

  localparam int CW = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;
  localparam int BW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16, S_EOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [2:0]    r_ones, w_ones_nxt;
  logic [3:0]    r_pid, w_pid_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic [15:0]   r_crc16, w_crc16_nxt;
  logic [BW-1:0] r_bytes, w_bytes_nxt;
  logic          r_j, w_j_nxt;
  logic          r_se0, w_se0_nxt;
  logic          r_done, w_done_nxt;
  logic          w_tick, w_bit, w_emit, w_slot_take;
  logic [7:0]    w_pid_byte;
`ifdef USB_TX_TOKEN_EN
  logic [10:0]   r_tok, w_tok_nxt;
  logic [4:0]    r_crc5, w_crc5_nxt;
`endif

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 16'hA001 : 16'h0000);
  endfunction

`ifdef USB_TX_TOKEN_EN
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 5'h14 : 5'h00);
  endfunction
`endif

  assign w_tick      = (r_cnt == CW'(BIT_SAMPLES - 1));
  assign w_pid_byte  = {~r_pid, r_pid};
  // A byte is taken only on a real (non-stuff) tick at the start of a slot.
  assign w_slot_take = (r_state == S_DATA) && w_tick && (r_ones != 3'd6) &&
                       (r_idx == 4'd0) && tx_valid_i && (r_bytes != BW'(MAX_BYTES));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ones  <= '0;
      r_pid   <= '0;
      r_byte  <= '0;
      r_crc16 <= 16'hFFFF;
      r_bytes <= '0;
      r_j     <= 1'b1;
      r_se0   <= 1'b0;
      r_done  <= 1'b0;
`ifdef USB_TX_TOKEN_EN
      r_tok   <= '0;
      r_crc5  <= 5'h1F;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_ones  <= w_ones_nxt;
      r_pid   <= w_pid_nxt;
      r_byte  <= w_byte_nxt;
      r_crc16 <= w_crc16_nxt;
      r_bytes <= w_bytes_nxt;
      r_j     <= w_j_nxt;
      r_se0   <= w_se0_nxt;
      r_done  <= w_done_nxt;
`ifdef USB_TX_TOKEN_EN
      r_tok   <= w_tok_nxt;
      r_crc5  <= w_crc5_nxt;
`endif
    end
  end

  // (r_state, r_idx) names the next bit to put on the line; each tick emits it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_state == S_IDLE || w_tick) ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_ones_nxt  = r_ones;
    w_pid_nxt   = r_pid;
    w_byte_nxt  = r_byte;
    w_crc16_nxt = r_crc16;
    w_bytes_nxt = r_bytes;
    w_j_nxt     = r_j;
    w_se0_nxt   = r_se0;
    w_done_nxt  = 1'b0;
    w_bit       = 1'b1;
    w_emit      = 1'b0;
`ifdef USB_TX_TOKEN_EN
    w_tok_nxt   = r_tok;
    w_crc5_nxt  = r_crc5;
`endif
    if (r_state == S_IDLE) begin
      if (pkt_start_i) begin
        w_state_nxt = S_SYNC;
        w_idx_nxt   = 4'd1;
        w_pid_nxt   = pid_i;
        w_ones_nxt  = 3'd0;
        w_se0_nxt   = 1'b0;
        w_bit       = 1'b0;
        w_emit      = 1'b1;
`ifdef USB_TX_TOKEN_EN
        w_tok_nxt   = token_i;
`endif
      end
    end else if (w_tick) begin
      if (r_ones == 3'd6) begin
        w_bit  = 1'b0;
        w_emit = 1'b1;
      end else begin
        w_idx_nxt = r_idx + 4'd1;
        case (r_state)
          S_SYNC: begin
            w_emit = 1'b1;
            w_bit  = (r_idx == 4'd7);
            if (r_idx == 4'd7) begin
              w_state_nxt = S_PID;
              w_idx_nxt   = 4'd0;
            end
          end
          S_PID: begin
            w_emit = 1'b1;
            w_bit  = w_pid_byte[r_idx[2:0]];
            if (r_idx == 4'd7) begin
              w_idx_nxt   = 4'd0;
              w_crc16_nxt = 16'hFFFF;
              w_bytes_nxt = '0;
              if (r_pid[2:0] == 3'b011) w_state_nxt = S_DATA;
`ifdef USB_TX_TOKEN_EN
              else if (r_pid[1:0] == 2'b01) begin
                w_state_nxt = S_TOKEN;
                w_crc5_nxt  = 5'h1F;
              end
`endif
              else w_state_nxt = S_EOP;
            end
          end
`ifdef USB_TX_TOKEN_EN
          S_TOKEN: begin
            w_emit     = 1'b1;
            w_bit      = r_tok[r_idx];
            w_crc5_nxt = crc5_step(r_crc5, r_tok[r_idx]);
            if (r_idx == 4'd10) begin
              w_state_nxt = S_CRC5;
              w_idx_nxt   = 4'd0;
            end
          end
          S_CRC5: begin
            w_emit = 1'b1;
            w_bit  = ~r_crc5[r_idx[2:0]];
            if (r_idx == 4'd4) begin
              w_state_nxt = S_EOP;
              w_idx_nxt   = 4'd0;
            end
          end
`endif
          S_DATA: begin
            w_emit = 1'b1;
            if (r_idx == 4'd0) begin
              if (w_slot_take) begin
                w_bit       = tx_data_i[0];
                w_byte_nxt  = tx_data_i;
                w_crc16_nxt = crc16_step(r_crc16, tx_data_i[0]);
                w_bytes_nxt = r_bytes + BW'(1);
              end else begin
                w_bit       = ~r_crc16[0];
                w_state_nxt = S_CRC16;
              end
            end else begin
              w_bit       = r_byte[r_idx[2:0]];
              w_crc16_nxt = crc16_step(r_crc16, r_byte[r_idx[2:0]]);
              if (r_idx == 4'd7) w_idx_nxt = 4'd0;
            end
          end
          S_CRC16: begin
            w_emit = 1'b1;
            w_bit  = ~r_crc16[r_idx];
            if (r_idx == 4'd15) begin
              w_state_nxt = S_EOP;
              w_idx_nxt   = 4'd0;
            end
          end
          S_EOP: begin
            w_ones_nxt = 3'd0;
            case (r_idx)
              4'd0, 4'd1: w_se0_nxt = 1'b1;
              4'd2: begin
                w_se0_nxt = 1'b0;
                w_j_nxt   = 1'b1;
              end
              default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 4'd0;
                w_done_nxt  = 1'b1;
              end
            endcase
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
    if (w_emit) begin
      w_j_nxt    = w_bit ? r_j : ~r_j;
      w_ones_nxt = w_bit ? r_ones + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    tx_ready_o = w_slot_take;
    busy_o     = (r_state != S_IDLE);
    tx_en_o    = (r_state != S_IDLE);
    done_o     = r_done;
    dp_tx_o    = ~r_se0 & r_j;
    dn_tx_o    = ~r_se0 & ~r_j;
  end

endmodule

// File: tb/tb_usb_pkt_tx.sv
// Bench for usb_pkt_tx: a packet-level model builds the expected line symbols
// per bit time; each packet is compared cycle by cycle against it.
module tb_usb_pkt_tx;
  localparam int BS   = 4;
  localparam int MAXB = 64;
  localparam logic [1:0] SJ = 2'b10, SK = 2'b01, SE0 = 2'b00;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pid = 4'h0;
  logic [7:0]  txd = 8'h00;
  logic        txv = 1'b0;
  logic        tx_ready, busy, done, tx_en, dp, dn;
`ifdef USB_TX_TOKEN_EN
  logic [10:0] token = 11'h000;
`endif

  usb_pkt_tx #(.BIT_SAMPLES(BS), .MAX_BYTES(MAXB)) dut (
    .clk_i(clk), .rstn_i(rstn), .pkt_start_i(start), .pid_i(pid),
`ifdef USB_TX_TOKEN_EN
    .token_i(token),
`endif
    .tx_data_i(txd), .tx_valid_i(txv), .tx_ready_o(tx_ready),
    .busy_o(busy), .done_o(done), .tx_en_o(tx_en), .dp_tx_o(dp), .dn_tx_o(dn)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_cnt, en_cnt, done_cnt;

  logic [7:0] src_q[$];
  logic [7:0] pay_q[$];
  logic       raw_q[$];
  logic       st_q[$];
  logic [1:0] sym_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16_q(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++)
        c = (c >> 1) ^ ((c[0] ^ q[i][b]) ? 16'hA001 : 16'h0000);
    return c;
  endfunction

  // Packet model: raw bits -> stuffing -> NRZI symbols -> EOP.
  task automatic build_model(input logic [3:0] p);
    logic [7:0]  pb;
    logic [15:0] c;
    logic [1:0]  lvl;
    int ones;
    raw_q.delete(); st_q.delete(); sym_q.delete();
    for (int i = 0; i < 7; i++) raw_q.push_back(1'b0);
    raw_q.push_back(1'b1);
    pb = {~p, p};
    for (int i = 0; i < 8; i++) raw_q.push_back(pb[i]);
    if (p == 4'h3 || p == 4'hB) begin
      foreach (pay_q[i])
        for (int b = 0; b < 8; b++) raw_q.push_back(pay_q[i][b]);
      c = ~crc16_q(pay_q);
      for (int i = 0; i < 16; i++) raw_q.push_back(c[i]);
    end
    ones = 0;
    foreach (raw_q[i]) begin
      st_q.push_back(raw_q[i]);
      if (raw_q[i]) begin
        ones++;
        if (ones == 6) begin
          st_q.push_back(1'b0);
          ones = 0;
        end
      end else ones = 0;
    end
    lvl = SJ;
    foreach (st_q[i]) begin
      if (!st_q[i]) lvl = (lvl == SJ) ? SK : SJ;
      sym_q.push_back(lvl);
    end
    sym_q.push_back(SE0);
    sym_q.push_back(SE0);
    sym_q.push_back(SJ);
  endtask

  // Driver + per-cycle compare for one packet.
  task automatic run_pkt(input logic [3:0] p, input int n_offer, input logic [7:0] base,
                         input int glitch_at, input int abort_at);
    int total;
    logic rdy, exp_en, exp_done;
    logic [1:0] exp_sym;
    src_q.delete(); pay_q.delete();
    for (int i = 0; i < n_offer; i++) begin
      src_q.push_back(8'(base + 8'(i * 37)));
      if (i < MAXB) pay_q.push_back(8'(base + 8'(i * 37)));
    end
    build_model(p);
    ready_cnt = 0; en_cnt = 0; done_cnt = 0;
    total = sym_q.size() * BS;
    @(negedge clk);
    pid = p; start = 1'b1;
    txv = (src_q.size() > 0);
    txd = txv ? src_q[0] : 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      exp_en   = (c < total);
      exp_sym  = (c < total) ? sym_q[c / BS] : SJ;
      exp_done = (c == total);
      chk("line", 32'({tx_en, dp, dn}), 32'({exp_en, exp_sym}));
      chk("busy", 32'(busy), 32'(exp_en));
      chk("done", 32'(done), 32'(exp_done));
      if (tx_en) en_cnt++;
      if (done) done_cnt++;
      rdy = tx_ready;
      if (rdy) ready_cnt++;
      if (c == abort_at) begin
        #1 rstn = 1'b0;
        #1;
        chk("abort_line", 32'({tx_en, dp, dn}), 32'({1'b0, SJ}));
        chk("abort_busy", 32'({busy, done, tx_ready}), 32'd0);
        txv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (c == glitch_at) begin
        start = 1'b1;
        pid = 4'h3;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (rdy) void'(src_q.pop_front());
      txv = (src_q.size() > 0);
      txd = txv ? src_q[0] : 8'h00;
    end
    chk("ready_count", 32'(ready_cnt), 32'(pay_q.size()));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("en_count", 32'(en_cnt), 32'(total));
    @(negedge clk);
    chk("idle_after", 32'({tx_en, dp, dn, busy, done}), 32'({1'b0, SJ, 1'b0, 1'b0}));
    txv = 1'b0;
  endtask

  initial begin
    string s;
    logic [1:0]  lit;
    logic [7:0]  rq[$];
    logic [15:0] c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_line", 32'({tx_en, dp, dn}), 32'({1'b0, SJ}));
    chk("reset_flags", 32'({busy, done, tx_ready}), 32'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // ACK: literal line pattern and 76-clock enable window
    run_pkt(4'h2, 0, 8'h00, -1, -1);
    s = "KJKJKJKKJJKJJKKK00J";
    chk("ack_len", 32'(sym_q.size()), 32'd19);
    for (int i = 0; i < 19; i++) begin
      lit = (s[i] == "K") ? SK : (s[i] == "J") ? SJ : SE0;
      chk("ack_sym", 32'(sym_q[i]), 32'(lit));
    end
    chk("ack_en76", 32'(en_cnt), 32'd76);

    // DATA1, empty payload: CRC 0x0000 -> 16 toggles, 35 bit times
    run_pkt(4'hB, 0, 8'h00, -1, -1);
    chk("d1_en140", 32'(en_cnt), 32'd140);
    chk("d1_ready0", 32'(ready_cnt), 32'd0);
    for (int i = 16; i < 32; i++)
      chk("d1_toggle", 32'(sym_q[i] != sym_q[i-1]), 32'd1);

    // DATA0 with 0xFF: stuff bit after fourth data bit
    run_pkt(4'h3, 1, 8'hFF, -1, -1);
    chk("ff_ready1", 32'(ready_cnt), 32'd1);
    chk("ff_stream", 32'({st_q[16], st_q[17], st_q[18], st_q[19], st_q[20],
                          st_q[21], st_q[22], st_q[23], st_q[24]}), 32'h1EF);

    // 70 bytes offered: capped at 64, CRC residual pinned
    run_pkt(4'h3, 70, 8'h11, -1, -1);
    chk("max_ready64", 32'(ready_cnt), 32'd64);
    rq = pay_q;
    c = ~crc16_q(pay_q);
    rq.push_back(c[7:0]);
    rq.push_back(c[15:8]);
    chk("crc_residual", 32'(crc16_q(rq)), 32'hB001);

    // further directed packets
    run_pkt(4'hB, 5, 8'h80, -1, -1);
    run_pkt(4'hA, 0, 8'h00, -1, -1);
    run_pkt(4'hE, 0, 8'h00, -1, -1);

    // reset mid-packet, then a clean packet
    run_pkt(4'h3, 5, 8'h40, -1, 100);
    run_pkt(4'h3, 2, 8'hA5, -1, -1);

    // start pulse during an ACK is ignored
    run_pkt(4'h2, 0, 8'h00, 30, -1);
    repeat (40) begin
      @(negedge clk);
      chk("no_second_pkt", 32'({tx_en, done}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
